// File: rtl/pool2d_stream_pkg.sv
// Shared constants and elaboration helpers for the streaming 2-D pooling stage.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    function automatic int acc_width(input int data_w, input int k);
        return data_w + 32'sd2 * $clog2(k);
    endfunction

    function automatic bit k_is_legal(input int k);
        return (k == 32'sd2) || (k == 32'sd4);
    endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// Input and output valid/ready streams of the pooling stage bundled in one interface.
interface pool2d_stream_if #(
    parameter int DATA_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pool2d_stream_combine.sv
// Window combine operator shared by the horizontal and vertical stages: max or sum.
module pool_combine
    import pool_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic             mode,
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] y
);

    // Select max or sum according to the frame mode
    always_comb begin
        y = a;
        if (mode == POOL_MAX) begin
            y = (a > b) ? a : b;
        end else begin
            y = a + b;
        end
    end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming KxK max/average pooler: raster pixels in, one pooled value per window out.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    pool2d_stream_if.slave   s,
    output logic             frame_done
);

    localparam int KB    = $clog2(K);
    localparam int ACC_W = acc_width(DATA_W, K);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int LB_D  = IMG_W / K;
    localparam int LB_AW = (LB_D > 32'sd1) ? $clog2(LB_D) : 32'sd1;
    localparam int SHIFT = 32'sd2 * KB;

    if (!k_is_legal(K)) begin : g_bad_k
        $error("pool2d_stream: K must be 2 or 4");
    end
    if ((IMG_W % K) != 32'sd0 || (IMG_H % K) != 32'sd0) begin : g_bad_dim
        $error("pool2d_stream: IMG_W and IMG_H must be multiples of K");
    end

    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [ACC_W-1:0]  h_acc_r;
    logic [ACC_W-1:0]  lb_r [LB_D];
    logic              mode_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              last_r;
    logic              frame_done_r;

    logic              accept_s;
    logic              grp_first_s;
    logic              grp_last_s;
    logic [KB-1:0]     row_ph_s;
    logic              load_s;
    logic              frame_end_s;
    logic [LB_AW-1:0]  lb_idx_s;
    logic [ACC_W-1:0]  pix_s;
    logic [ACC_W-1:0]  lb_rd_s;
    logic [ACC_W-1:0]  h_s;
    logic [ACC_W-1:0]  v_s;
    logic [DATA_W-1:0] res_s;

    assign s.in_ready   = !out_valid_r || s.out_ready;
    assign s.out_valid  = out_valid_r;
    assign s.out_data   = out_data_r;
    assign frame_done   = frame_done_r;

    assign accept_s    = s.in_valid && s.in_ready;
    assign grp_first_s = (col_r[KB-1:0] == KB'(0));
    assign grp_last_s  = (col_r[KB-1:0] == KB'(K - 1));
    assign row_ph_s    = row_r[KB-1:0];
    assign load_s      = accept_s && grp_last_s && (row_ph_s == KB'(K - 1));
    assign frame_end_s = (col_r == COL_W'(IMG_W - 1)) && (row_r == ROW_W'(IMG_H - 1));
    assign lb_idx_s    = LB_AW'(col_r >> KB);
    assign pix_s       = ACC_W'(s.in_data);
    assign lb_rd_s     = lb_r[lb_idx_s];

    pool_combine #(.ACC_W(ACC_W)) u_h_comb (
        .mode (mode_r),
        .a    (h_acc_r),
        .b    (pix_s),
        .y    (h_s)
    );

    pool_combine #(.ACC_W(ACC_W)) u_v_comb (
        .mode (mode_r),
        .a    (lb_rd_s),
        .b    (h_s),
        .y    (v_s)
    );

    // Average divides by K*K with a plain shift, so the result is floored
    always_comb begin
        res_s = DATA_W'(v_s);
        if (mode_r == POOL_AVG) begin
            res_s = DATA_W'(v_s >> SHIFT);
        end else begin
            res_s = DATA_W'(v_s);
        end
    end

    // Raster position, horizontal accumulator and frame mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            h_acc_r <= {ACC_W{1'b0}};
            mode_r  <= POOL_MAX;
        end else if (accept_s) begin
            h_acc_r <= grp_first_s ? pix_s : h_s;
            if (col_r == {COL_W{1'b0}} && row_r == {ROW_W{1'b0}}) begin
                mode_r <= mode;
            end
            if (col_r == COL_W'(IMG_W - 1)) begin
                col_r <= {COL_W{1'b0}};
                row_r <= (row_r == ROW_W'(IMG_H - 1)) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Line buffer of partial column results; every entry is rewritten on the first row of a band
    always_ff @(posedge clk) begin
        if (accept_s && grp_last_s && row_ph_s != KB'(K - 1)) begin
            lb_r[lb_idx_s] <= (row_ph_s == KB'(0)) ? h_s : v_s;
        end
    end

    // Single-entry output register and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            last_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && s.out_ready && last_r;
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= res_s;
                last_r      <= frame_end_s;
            end else if (s.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed and randomized bench for pool2d_stream (K=2 4x4 and K=4 8x8 instances).
module tb_pool2d_stream;

    logic clk;
    logic rst_n;
    logic mode2, mode4;
    logic fd2, fd4;

    pool2d_stream_if #(.DATA_W(6)) if2 ();
    pool2d_stream_if #(.DATA_W(6)) if4 ();

    pool2d_stream #(.DATA_W(6), .IMG_W(4), .IMG_H(4), .K(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .s(if2.slave), .frame_done(fd2)
    );
    pool2d_stream #(.DATA_W(6), .IMG_W(8), .IMG_H(8), .K(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .s(if4.slave), .frame_done(fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int sel;
    int km, wm, hm;
    int mrow, mcol;
    bit mmode;
    int pix [8][8];
    int exp_q [$];
    bit last_q [$];
    bit exp_fd;
    int got_log [$];
    int fd_cnt;
    int bp_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_geom(input int s);
        sel = s;
        km = (s == 0) ? 2 : 4;
        wm = (s == 0) ? 4 : 8;
        hm = wm;
    endtask

    // Reference: a pixel lands in the frame array; a completed window is pooled from it
    task automatic model_beat(input int d, input bit md);
        int mx, sum, v;
        if (mrow == 0 && mcol == 0) mmode = md;
        pix[mrow][mcol] = d;
        if (mrow % km == km - 1 && mcol % km == km - 1) begin
            mx = 0; sum = 0;
            for (int r = mrow - km + 1; r <= mrow; r++)
                for (int c = mcol - km + 1; c <= mcol; c++) begin
                    sum += pix[r][c];
                    if (pix[r][c] > mx) mx = pix[r][c];
                end
            v = mmode ? sum / (km * km) : mx;
            exp_q.push_back(v);
            last_q.push_back(mrow == hm - 1 && mcol == wm - 1);
        end
        mcol++;
        if (mcol == wm) begin
            mcol = 0;
            mrow = (mrow == hm - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic tick(input bit iv, input logic [5:0] d, input bit ord, input bit md, output bit acc);
        bit ov_e, acc_out;
        logic obs_ov, obs_ir, obs_fd;
        logic [5:0] obs_od;
        if (sel == 0) begin
            if2.in_valid = iv; if2.in_data = d; if2.out_ready = ord; mode2 = md;
            if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        end else begin
            if4.in_valid = iv; if4.in_data = d; if4.out_ready = ord; mode4 = md;
            if2.in_valid = 1'b0; if2.out_ready = 1'b1;
        end
        #1;
        obs_ov = (sel == 0) ? if2.out_valid : if4.out_valid;
        obs_ir = (sel == 0) ? if2.in_ready  : if4.in_ready;
        obs_od = (sel == 0) ? if2.out_data  : if4.out_data;
        obs_fd = (sel == 0) ? fd2 : fd4;
        ov_e = (exp_q.size() != 0);
        chk("frame_done", 32'(obs_fd), 32'(exp_fd));
        chk("out_valid", 32'(obs_ov), 32'(ov_e));
        if (ov_e) chk("out_data", 32'(obs_od), 32'(exp_q[0]));
        chk("in_ready", 32'(obs_ir), 32'(!ov_e || ord));
        if (obs_fd === 1'b1) fd_cnt++;
        acc_out = ov_e && ord;
        acc = iv && (!ov_e || ord);
        exp_fd = 1'b0;
        if (acc_out) begin
            got_log.push_back(int'(obs_od));
            exp_fd = last_q[0];
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
        end
        if (acc) model_beat(int'(d), md);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(sel == 0 ? if2.out_valid : if4.out_valid), 32'd0);
        chk("rst_out_data",  32'(sel == 0 ? if2.out_data  : if4.out_data),  32'd0);
        chk("rst_frame_done", 32'(sel == 0 ? fd2 : fd4), 32'd0);
        chk("rst_in_ready",  32'(sel == 0 ? if2.in_ready  : if4.in_ready),  32'd1);
        mrow = 0; mcol = 0; mmode = 1'b0; exp_fd = 1'b0;
        exp_q.delete(); last_q.delete(); got_log.delete(); fd_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // kind: 0 raster 1..N, 1 all 63, 2 random pixels
    task automatic run_frame(input int kind, input bit md0, input bit md1, input int flip_at, input bit rnd);
        bit acc, iv, ord, md;
        logic [5:0] d;
        for (int i = 0; i < wm * hm; i++) begin
            d = (kind == 0) ? 6'(i + 1) : (kind == 1) ? 6'd63 : 6'($urandom_range(0, 63));
            md = (i >= flip_at) ? md1 : md0;
            acc = 1'b0;
            while (!acc) begin
                iv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (bp_hold > 0 && exp_q.size() != 0) begin
                    ord = 1'b0;
                    bp_hold--;
                end else begin
                    ord = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                tick(iv, d, ord, md, acc);
            end
        end
    endtask

    task automatic drain(input bit md);
        bit acc;
        repeat (4) tick(1'b0, 6'd0, 1'b1, md, acc);
    endtask

    task automatic expect_log(input string tag, input int a, input int b, input int c, input int d);
        int e [4];
        e = '{a, b, c, d};
        chk({tag, "_count"}, 32'(got_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk(tag, (i < got_log.size()) ? 32'(got_log[i]) : 32'hFFFF_FFFF, 32'(e[i]));
        got_log.delete();
    endtask

    task automatic expect_fd(input string tag, input int n);
        chk(tag, 32'(fd_cnt), 32'(n));
        fd_cnt = 0;
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0;
        mode2 = 1'b0; mode4 = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = 6'd0; if2.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = 6'd0; if4.out_ready = 1'b0;
        bp_hold = 0;
        set_geom(0);
        @(negedge clk);
        do_reset();

        run_frame(0, 1'b0, 1'b0, 999, 1'b0);
        drain(1'b0);
        expect_log("max_k2", 6, 8, 14, 16);
        expect_fd("max_k2_fd", 1);

        run_frame(0, 1'b1, 1'b1, 999, 1'b0);
        drain(1'b1);
        expect_log("avg_k2", 3, 5, 11, 13);
        expect_fd("avg_k2_fd", 1);

        bp_hold = 5;
        run_frame(0, 1'b0, 1'b0, 999, 1'b0);
        drain(1'b0);
        expect_log("bp_k2", 6, 8, 14, 16);
        expect_fd("bp_k2_fd", 1);

        run_frame(0, 1'b0, 1'b1, 4, 1'b0);
        run_frame(0, 1'b1, 1'b1, 0, 1'b0);
        drain(1'b1);
        chk("b2b_count", 32'(got_log.size()), 32'd8);
        if (got_log.size() == 8) begin
            got_log = got_log[4:7];
            expect_log("b2b_frame2", 3, 5, 11, 13);
        end else begin
            got_log.delete();
        end
        expect_fd("b2b_fd", 2);

        for (int i = 0; i < 7; i++) tick(1'b1, 6'(i + 1), 1'b1, 1'b0, acc);
        do_reset();
        run_frame(0, 1'b0, 1'b0, 999, 1'b0);
        drain(1'b0);
        expect_log("post_rst", 6, 8, 14, 16);
        expect_fd("post_rst_fd", 1);

        for (int f = 0; f < 3; f++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            run_frame(2, m, 1'($urandom_range(0, 1)), $urandom_range(1, 15), 1'b1);
        end
        drain(1'b0);
        expect_fd("rand_k2_fd", 3);
        got_log.delete();

        set_geom(1);
        do_reset();
        run_frame(1, 1'b0, 1'b0, 999, 1'b0);
        drain(1'b0);
        expect_log("sat_max_k4", 63, 63, 63, 63);
        run_frame(1, 1'b1, 1'b1, 999, 1'b0);
        drain(1'b1);
        expect_log("sat_avg_k4", 63, 63, 63, 63);
        expect_fd("sat_k4_fd", 2);

        for (int f = 0; f < 2; f++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            run_frame(2, m, m, 999, 1'b1);
        end
        drain(1'b0);
        expect_fd("rand_k4_fd", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Parametrised streaming 2-D pooling stage for the CNN datapath; successor to the fixed 2×2 max pooler. It accepts one raster-order pixel per accepted beat and emits one pooled value per K×K window, selectable max or average. It keeps its own row and column position, so no external row strobe is used. Valid/ready handshakes on both sides let it sit between any two stages of the layer chain.

## Interface
- DATA_W, 6, pixel width (unsigned)
- IMG_W, 16, input row length in pixels; must be a multiple of K
- IMG_H, 16, input rows per frame; must be a multiple of K
- K, 2, window size and stride; legal values 2 or 4 (elaboration error otherwise)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = max, 1 = average; sampled only when the first pixel of a frame is accepted
- in_valid  in  1  input beat valid
- in_data  in  DATA_W  input pixel
- in_ready  out  1  block can accept a beat
- out_valid  out  1  pooled value valid
- out_data  out  DATA_W  pooled value
- out_ready  in  1  downstream accepts
- frame_done  out  1  one-cycle pulse when the last output of a frame is accepted

## Operation
- A beat is accepted when in_valid and in_ready are both high. Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted beats. col wraps to 0 and increments row; row wraps to 0 at frame end.
- Accumulator width ACC_W = DATA_W + 2·log2(K).
- Horizontal stage, register h_acc:
  - Max mode: h_acc holds the running max of the current K pixels.
  - Average mode: h_acc holds the running sum.
  - Loaded (not combined) on col mod K == 0.
- Vertical stage, line buffer of IMG_W/K entries, width ACC_W, indexed by col/K. On the last pixel of a horizontal group (col mod K == K-1), with h = combined h_acc and current pixel:
  - row mod K == 0: entry ← h.
  - row mod K in 1..K-2: entry ← combine(entry, h).
  - row mod K == K-1: result = combine(entry, h); the output register is loaded; the entry is not written.
- Output value:
  - Max mode: result.
  - Average mode: result >> 2·log2(K), truncated (floor), no rounding.
- The frame mode register latches `mode` on the accepted beat with row == 0 and col == 0. Changes to `mode` at any other time are ignored.
- The line buffer is not reset. Every entry is overwritten at row mod K == 0 before it is read.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, frame_done=0, col=0, row=0, h_acc=0, frame mode=max.
- Latency: out_valid rises on the clock edge that accepts the window's final pixel, i.e. it is visible the cycle after that beat.
- Single-entry output register:
  - out_valid falls on acceptance unless a new result loads in the same cycle; in that case it stays high with the new data.
  - out_data is held stable while out_valid && !out_ready.
- in_ready = !out_valid || out_ready.
- Throughput: one beat per cycle with no backpressure.
- Back-to-back frames: no bubble is required between the last pixel of one frame and the first pixel of the next.
- frame_done pulses the cycle after the output for window (IMG_H/K-1, IMG_W/K-1) is accepted.
- rst_n asserted mid-frame: all state returns to reset values immediately. A pending output is discarded. The next accepted beat is treated as pixel (0,0).

## Structure
- Package pool_pkg:
  - Mode constants POOL_MAX=0, POOL_AVG=1.
  - Function that computes ACC_W from DATA_W and K.
  - Legal-K check.
- Sub-module pool_combine: combinational, ACC_W wide, inputs mode/a/b, output max(a,b) or a+b. It is instanced for both the horizontal and the vertical stage.
- Everything else lives in pool2d_stream: counters, h_acc, line buffer, output register, frame_done.

## Test plan
- **Max, K=2, 4×4 frame, rows 1..16 raster (pixel = r·4+c+1):** out_data sequence 6, 8, 14, 16; frame_done pulses once after 16 is accepted.
- **Average, K=2, same frame:** outputs 3, 5, 11, 13 (floor of 3.5, 5.5, 11.5, 13.5).
- **Backpressure:** hold out_ready=0 for 5 cycles after the first output while in_valid stays high. in_ready drops as soon as the output is pending; out_data stays 6; no beats are lost. The sequence completes unchanged after release.
- **Back-to-back frames with mode toggled mid-frame:**
  - Frame 1 is max; mode flips to average during pixel 5. Frame 1 outputs stay max.
  - Frame 2 starts the next cycle with mode=1 and produces average results.
- **Reset mid-frame:** assert rst_n low after 7 beats. All outputs read 0 and in_ready=1. A full fresh frame afterwards yields 6, 8, 14, 16.
- **K=4, DATA_W=6, all pixels 63, 8×8 frame:** max and average both give 63 for each of the 4 outputs; no overflow in the 10-bit accumulator.
